// File: rtl/kmac_kdf_host_pkg.sv
// +----------------------------------------------------------------------+
// | kmac_kdf_host_pkg: shared types, widths and strobe helper for the    |
// | KMAC KDF requester.                              Revision: 1.0       |
// +----------------------------------------------------------------------+
`default_nettype none

package kmac_kdf_host_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } kdf_state_e;

   localparam int unsigned DataWidth   = 64;
   localparam int unsigned DigestWidth = 256;
   localparam int unsigned StrbWidth   = DataWidth / 8;

   localparam int unsigned RspErrKmacIdx    = 0;
   localparam int unsigned RspErrTimeoutIdx = 1;

   // Final-beat strobe: low (len mod 8) lanes, all eight when that is 0, none for len 0.
   function automatic logic [StrbWidth-1:0] last_strb(input logic [31:0] len);
      logic [3:0] n;
      logic [8:0] mask;
      n    = (len[2:0] == 3'd0) ? 4'd8 : {1'b0, len[2:0]};
      mask = (9'd1 << n) - 9'd1;
      if (len == 32'd0) begin
         mask = '0;
      end
      return mask[StrbWidth-1:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/kmac_kdf_strb_gen.sv
// +----------------------------------------------------------------------+
// | kmac_kdf_strb_gen: beat count and final-beat strobe from a length.   |
// |                                                  Revision: 1.0       |
// +----------------------------------------------------------------------+
`default_nettype none

module kmac_kdf_strb_gen
   import kmac_kdf_host_pkg::*;
#(
   parameter int unsigned LW = 9
) (
   input  logic [LW-1:0]        len_i,
   output logic [LW-1:0]        beats_o,
   output logic [StrbWidth-1:0] last_strb_o
);

   logic [LW:0] len_round;

   // A zero-length message still needs one (empty) beat to carry last.
   assign len_round   = {1'b0, len_i} + (LW+1)'(7);
   assign beats_o     = (len_i == '0) ? LW'(1) : LW'(len_round >> 3);
   assign last_strb_o = last_strb(32'(len_i));

endmodule

`default_nettype wire

// File: rtl/kmac_kdf_host.sv
// +----------------------------------------------------------------------+
// | kmac_kdf_host: requester that streams a message to KMAC's KDF port   |
// | and returns the digest. Optional WAIT watchdog: KDF_TIMEOUT_EN.      |
// |                                                  Revision: 1.0       |
// +----------------------------------------------------------------------+
`default_nettype none

module kmac_kdf_host
   import kmac_kdf_host_pkg::*;
#(
   parameter int unsigned MaxLenBytes   = 256,
   parameter int unsigned TimeoutCycles = 1024,
   localparam int unsigned LW           = $clog2(MaxLenBytes + 1)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_valid_i,
   output logic                   start_ready_o,
   input  logic [LW-1:0]          start_len_i,
   input  logic                   src_valid_i,
   output logic                   src_ready_o,
   input  logic [DataWidth-1:0]   src_data_i,
   output logic                   kdf_valid_o,
   output logic [DataWidth-1:0]   kdf_data_o,
   output logic [StrbWidth-1:0]   kdf_strb_o,
   output logic                   kdf_last_o,
   input  logic                   kdf_ready_i,
   input  logic                   kdf_done_i,
   input  logic [DigestWidth-1:0] kdf_digest_share0_i,
   input  logic [DigestWidth-1:0] kdf_digest_share1_i,
   input  logic                   kdf_error_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [DigestWidth-1:0] rsp_share0_o,
   output logic [DigestWidth-1:0] rsp_share1_o,
   output logic [1:0]             rsp_err_o,
   output logic                   rsp_abort_o
);

   kdf_state_e             state_q, state_d;
   logic [LW-1:0]          len_q, len_d;
   logic [LW-1:0]          loaded_q, loaded_d;
   logic                   valid_q, valid_d;
   logic [DataWidth-1:0]   data_q, data_d;
   logic [StrbWidth-1:0]   strb_q, strb_d;
   logic                   last_q, last_d;
   logic [DigestWidth-1:0] share0_q, share0_d;
   logic [DigestWidth-1:0] share1_q, share1_d;
   logic [1:0]             err_q, err_d;
   logic                   abort_q, abort_d;

   logic [LW-1:0]          beats;
   logic [StrbWidth-1:0]   fin_strb;
   logic [LW-1:0]          len_sat;
   logic                   src_fire;
   logic                   kdf_fire;
   logic                   timeout_hit;

   kmac_kdf_strb_gen #(
      .LW (LW)
   ) u_strb_gen (
      .len_i       (len_q),
      .beats_o     (beats),
      .last_strb_o (fin_strb)
   );

   assign len_sat  = (start_len_i > LW'(MaxLenBytes)) ? LW'(MaxLenBytes) : start_len_i;
   assign kdf_fire = valid_q && kdf_ready_i;

   // The output register may be refilled in the same cycle its current beat is taken.
   assign src_ready_o = (state_q == ST_SEND) && (loaded_q < beats) && (!valid_q || kdf_ready_i);
   assign src_fire    = src_ready_o && src_valid_i;

`ifdef KDF_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TimeoutCycles + 1);
   logic [TW-1:0] tmo_q, tmo_d;

   // Held at zero outside WAIT, so every entry to WAIT starts a fresh count.
   always_comb begin
      tmo_d = '0;
      if (state_q == ST_WAIT) begin
         tmo_d = tmo_q + TW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end

   assign timeout_hit = (state_q == ST_WAIT) && (tmo_q == TW'(TimeoutCycles - 1));
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = ^TimeoutCycles;
   assign timeout_hit    = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      loaded_d = loaded_q;
      valid_d  = valid_q;
      data_d   = data_q;
      strb_d   = strb_q;
      last_d   = last_q;
      share0_d = share0_q;
      share1_d = share1_q;
      err_d    = err_q;
      abort_d  = abort_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start_valid_i) begin
               len_d    = len_sat;
               loaded_d = '0;
               err_d    = '0;
               abort_d  = 1'b0;
               state_d  = ST_SEND;
            end
         end
         ST_SEND: begin
            if (kdf_done_i) begin
               share0_d                = kdf_digest_share0_i;
               share1_d                = kdf_digest_share1_i;
               err_d                   = '0;
               err_d[RspErrKmacIdx]    = kdf_error_i;
               abort_d                 = 1'b1;
               valid_d                 = 1'b0;
               state_d                 = ST_RESP;
            end else begin
               if (src_fire) begin
                  data_d   = src_data_i;
                  last_d   = (loaded_q == beats - LW'(1));
                  strb_d   = last_d ? fin_strb : {StrbWidth{1'b1}};
                  loaded_d = loaded_q + LW'(1);
                  valid_d  = 1'b1;
               end else if (kdf_fire) begin
                  valid_d = 1'b0;
               end
               if (kdf_fire && last_q) begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (kdf_done_i) begin
               share0_d             = kdf_digest_share0_i;
               share1_d             = kdf_digest_share1_i;
               err_d                = '0;
               err_d[RspErrKmacIdx] = kdf_error_i;
               state_d              = ST_RESP;
            end else if (timeout_hit) begin
               share0_d                = '0;
               share1_d                = '0;
               err_d                   = '0;
               err_d[RspErrTimeoutIdx] = 1'b1;
               state_d                 = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         len_q    <= '0;
         loaded_q <= '0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         strb_q   <= '0;
         last_q   <= 1'b0;
         share0_q <= '0;
         share1_q <= '0;
         err_q    <= '0;
         abort_q  <= 1'b0;
      end else begin
         len_q    <= len_d;
         loaded_q <= loaded_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         strb_q   <= strb_d;
         last_q   <= last_d;
         share0_q <= share0_d;
         share1_q <= share1_d;
         err_q    <= err_d;
         abort_q  <= abort_d;
      end
   end

   assign start_ready_o = (state_q == ST_IDLE);
   assign kdf_valid_o   = valid_q;
   assign kdf_data_o    = data_q;
   assign kdf_strb_o    = strb_q;
   assign kdf_last_o    = last_q;
   assign rsp_valid_o   = (state_q == ST_RESP);
   assign rsp_share0_o  = share0_q;
   assign rsp_share1_o  = share1_q;
   assign rsp_err_o     = err_q;
   assign rsp_abort_o   = abort_q;

endmodule

`default_nettype wire

// File: tb/tb_kmac_kdf_host.sv
// +----------------------------------------------------------------------+
// | tb_kmac_kdf_host: randomized self-checking bench for kmac_kdf_host.  |
// | Timeout scenario runs when KDF_TIMEOUT_EN is defined. Revision: 1.0  |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_kmac_kdf_host;

   localparam int MAXLEN = 256;
`ifdef KDF_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 1024;
`endif
   localparam int LW = $clog2(MAXLEN + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_valid = 1'b0;
   logic          start_ready;
   logic [LW-1:0] start_len = '0;
   logic          src_valid = 1'b0;
   logic          src_ready;
   logic [63:0]   src_data = '0;
   logic          kdf_valid;
   logic [63:0]   kdf_data;
   logic [7:0]    kdf_strb;
   logic          kdf_last;
   logic          kdf_ready = 1'b0;
   logic          kdf_done = 1'b0;
   logic [255:0]  dig0 = '0;
   logic [255:0]  dig1 = '0;
   logic          kdf_err = 1'b0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [255:0]  rsp_s0;
   logic [255:0]  rsp_s1;
   logic [1:0]    rsp_err;
   logic          rsp_abort;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   kmac_kdf_host #(
      .MaxLenBytes   (MAXLEN),
      .TimeoutCycles (TMO)
   ) dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .start_valid_i       (start_valid),
      .start_ready_o       (start_ready),
      .start_len_i         (start_len),
      .src_valid_i         (src_valid),
      .src_ready_o         (src_ready),
      .src_data_i          (src_data),
      .kdf_valid_o         (kdf_valid),
      .kdf_data_o          (kdf_data),
      .kdf_strb_o          (kdf_strb),
      .kdf_last_o          (kdf_last),
      .kdf_ready_i         (kdf_ready),
      .kdf_done_i          (kdf_done),
      .kdf_digest_share0_i (dig0),
      .kdf_digest_share1_i (dig1),
      .kdf_error_i         (kdf_err),
      .rsp_valid_o         (rsp_valid),
      .rsp_ready_i         (rsp_ready),
      .rsp_share0_o        (rsp_s0),
      .rsp_share1_o        (rsp_s1),
      .rsp_err_o           (rsp_err),
      .rsp_abort_o         (rsp_abort)
   );

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Reference strobe for beat b of a message of eff bytes split into nb beats.
   function automatic logic [7:0] exp_strb(input int eff, input int nb, input int b);
      int n;
      if (b < nb - 1) return 8'hFF;
      if (eff == 0) return 8'h00;
      n = (eff % 8 == 0) ? 8 : eff % 8;
      return 8'((1 << n) - 1);
   endfunction

   task automatic reset_checks();
      chk("rst_start_ready", start_ready, 1);
      chk("rst_src_ready", src_ready, 0);
      chk("rst_kdf_valid", kdf_valid, 0);
      chk("rst_kdf_data", kdf_data, 0);
      chk("rst_kdf_strb", kdf_strb, 0);
      chk("rst_kdf_last", kdf_last, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_s0", rsp_s0, 0);
      chk("rst_rsp_s1", rsp_s1, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_abort", rsp_abort, 0);
   endtask

   // mode 0: normal (done_dly < 0 means never send done), 1: done after beat 1, 2: reset in WAIT
   task automatic run_txn(input int len, input int stall_pct, input int done_dly,
                          input int mode, input bit stall3);
      logic [63:0]  words[$];
      logic [255:0] e_s0, e_s1;
      logic [1:0]   e_err;
      logic [63:0]  pd;
      logic [7:0]   ps;
      logic         pl;
      bit           pstall, done_now, done_prev, finished;
      int           eff, nb, src_cnt, beat, wait_cnt, stall_left, cyc;

      eff = (len > MAXLEN) ? MAXLEN : len;
      nb  = (eff == 0) ? 1 : (eff + 7) / 8;
      for (int i = 0; i < nb; i++) words.push_back({$urandom, $urandom});
      e_s0 = '0; e_s1 = '0; e_err = 2'b10;
      pd = '0; ps = '0; pl = 1'b0;
      pstall = 0; done_prev = 0; finished = 0;
      src_cnt = 0; beat = 0; wait_cnt = 0; stall_left = 3; cyc = 0;

      @(negedge clk);
      start_valid = 1'b1;
      start_len   = LW'(len);
      #1 chk("start_ready_idle", start_ready, 1);
      @(negedge clk);
      start_valid = 1'b0;
      chk("start_ready_send", start_ready, 0);

      while (!finished && cyc < 3000) begin
         cyc++;
         if (done_prev) chk("rsp_after_done", rsp_valid, 1);
         if (rsp_valid) begin
            finished = 1;
         end else begin
            if (beat == nb) wait_cnt++;
            if (mode == 2 && beat == nb && wait_cnt == 2) begin
               #2 rst = 1'b1;
               #1 reset_checks();
               src_valid = 1'b0;
               kdf_ready = 1'b0;
               @(negedge clk);
               rst = 1'b0;
               return;
            end
            src_valid = ($urandom_range(0, 99) < 80);
            src_data  = (src_cnt < nb) ? words[src_cnt] : {$urandom, $urandom};
            if (stall3 && beat == 0 && kdf_valid && stall_left > 0) begin
               kdf_ready = 1'b0;
               stall_left--;
            end else begin
               kdf_ready = ($urandom_range(0, 99) >= stall_pct);
            end
            done_now = 0;
            if (mode == 0 && done_dly > 0 && beat == nb && wait_cnt == done_dly) done_now = 1;
            if (mode == 1 && beat == 1) begin
               done_now  = 1;
               kdf_ready = 1'b0;
            end
            kdf_done = done_now;
            if (done_now) begin
               dig0    = rnd256();
               dig1    = rnd256();
               kdf_err = 1'($urandom);
               e_s0    = dig0;
               e_s1    = dig1;
               e_err   = {1'b0, kdf_err};
            end
            #1;
            if (pstall) begin
               chk("stall_valid", kdf_valid, 1);
               chk("stall_data", kdf_data, pd);
               chk("stall_strb", kdf_strb, ps);
               chk("stall_last", kdf_last, pl);
            end
            if (kdf_valid && kdf_ready) begin
               chk("beat_data", kdf_data, words[beat]);
               chk("beat_strb", kdf_strb, exp_strb(eff, nb, beat));
               chk("beat_last", kdf_last, (beat == nb - 1));
               beat++;
            end
            if (src_valid && src_ready) src_cnt++;
            pstall    = kdf_valid && !kdf_ready;
            pd        = kdf_data;
            ps        = kdf_strb;
            pl        = kdf_last;
            done_prev = done_now;
            @(negedge clk);
            kdf_done = 1'b0;
         end
      end
      src_valid = 1'b0;
      kdf_ready = 1'b0;
      if (!finished) begin
         chk("txn_bound", 0, 1);
         return;
      end

      if (mode == 1) begin
         chk("abort_kdf_valid", kdf_valid, 0);
         chk("abort_flag", rsp_abort, 1);
      end else begin
         chk("src_handshakes", src_cnt, nb);
         chk("beats_sent", beat, nb);
         chk("abort_flag", rsp_abort, 0);
      end
      if (done_dly < 0 && mode == 0) chk("timeout_wait_cycles", wait_cnt, TMO);
      chk("rsp_share0", rsp_s0, e_s0);
      chk("rsp_share1", rsp_s1, e_s1);
      chk("rsp_err", rsp_err, e_err);

      // RESP must hold and ignore a stray done while the result is not consumed.
      repeat ($urandom_range(1, 3)) begin
         kdf_done = 1'b1;
         dig0     = rnd256();
         @(negedge clk);
         kdf_done = 1'b0;
         chk("rsp_hold_valid", rsp_valid, 1);
         chk("rsp_hold_share0", rsp_s0, e_s0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("idle_start_ready", start_ready, 1);
      chk("idle_rsp_valid", rsp_valid, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset_checks();
      rst = 1'b0;
      @(negedge clk);

      // done while idle is ignored
      kdf_done = 1'b1;
      dig0     = rnd256();
      @(negedge clk);
      kdf_done = 1'b0;
      chk("idle_done_ignored", rsp_valid, 0);
      chk("idle_done_start_ready", start_ready, 1);

      run_txn(16, 0, 5, 0, 0);
      run_txn(13, 0, 3, 0, 1);
      run_txn(0, 20, 2, 0, 0);
      run_txn(24, 0, 0, 1, 0);
      run_txn(300, 30, 1, 0, 0);
      run_txn(256, 0, 2, 0, 0);
      for (int t = 0; t < 8; t++) begin
         run_txn($urandom_range(0, 300), $urandom_range(0, 50), $urandom_range(1, 6), 0, 0);
      end
`ifdef KDF_TIMEOUT_EN
      run_txn(16, 0, -1, 0, 0);
`endif

      run_txn(16, 0, 0, 2, 0);
      kdf_done = 1'b1;
      dig0     = rnd256();
      @(negedge clk);
      kdf_done = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("post_rst_no_rsp", rsp_valid, 0);
         chk("post_rst_start_ready", start_ready, 1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
